// File: rtl/register_file_param.sv
// Parametrised register file with a sequential clear on reset, optional
// hardwired-zero register 0 and optional same-cycle write-to-read bypass.
module register_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_register_1,
  input  logic [ADDR_WIDTH-1:0] read_register_2,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  sig_reg_write,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  ready
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] CLR_START = (ZERO_REG != 0) ? ADDR_WIDTH'(1) : '0;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_clear_ptr;
  logic [ADDR_WIDTH-1:0] w_next_ptr;
  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic                  w_write_en;
  logic                  w_zero_wr;

  // State register; reset always restarts the clear from its start pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_clear_ptr <= CLR_START;
    end else begin
      r_state     <= w_next_state;
      r_clear_ptr <= w_next_ptr;
    end
  end

  // Next state: the edge that clears the last register enters READY; the
  // pointer stops at the last index instead of wrapping.
  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_clear_ptr;
    if (r_state == ST_CLEAR) begin
      if (r_clear_ptr == CLR_LAST) begin
        w_next_state = ST_READY;
      end else begin
        w_next_ptr = r_clear_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  // Write port: sig_reg_write is a one-cycle request accepted only while
  // ready=1; requests during CLEAR or reset are dropped, never queued.
  assign w_zero_wr  = (ZERO_REG != 0) && (write_register == '0);
  assign w_write_en = (r_state == ST_READY) && sig_reg_write && !w_zero_wr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        r_regs[r_clear_ptr] <= '0;
      end else if (w_write_en) begin
        r_regs[write_register] <= write_data;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] v;
    v = r_regs[addr];
    if (r_state != ST_READY) begin
      v = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      v = '0;
    end else if ((BYPASS != 0) && sig_reg_write && (addr == write_register)) begin
      v = write_data;
    end
    return v;
  endfunction

  // Outputs: ready comes straight from the state register.
  always_comb begin
    ready       = (r_state == ST_READY);
    read_data_1 = read_port(read_register_1);
    read_data_2 = read_port(read_register_2);
  end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: three configurations checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_register_file_param;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instances a (bypass) and b (no bypass) share one stimulus set.
  logic        rst_a, we_a;
  logic [4:0]  ra1_a, ra2_a, wa_a;
  logic [31:0] wd_a;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        rdy_a, rdy_b;

  logic        rst_c, we_c;
  logic [2:0]  ra1_c, ra2_c, wa_c;
  logic [15:0] wd_c;
  logic [15:0] rd1_c, rd2_c;
  logic        rdy_c;

  register_file_param #(.DATA_WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .reset(rst_a), .read_register_1(ra1_a), .read_register_2(ra2_a),
    .write_register(wa_a), .write_data(wd_a), .sig_reg_write(we_a),
    .read_data_1(rd1_a), .read_data_2(rd2_a), .ready(rdy_a));

  register_file_param #(.DATA_WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk(clk), .reset(rst_a), .read_register_1(ra1_a), .read_register_2(ra2_a),
    .write_register(wa_a), .write_data(wd_a), .sig_reg_write(we_a),
    .read_data_1(rd1_b), .read_data_2(rd2_b), .ready(rdy_b));

  register_file_param #(.DATA_WIDTH(16), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) u_c (
    .clk(clk), .reset(rst_c), .read_register_1(ra1_c), .read_register_2(ra2_c),
    .write_register(wa_c), .write_data(wd_c), .sig_reg_write(we_c),
    .read_data_1(rd1_c), .read_data_2(rd2_c), .ready(rdy_c));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: ready appears a fixed number of edges after reset
  // is released, at which point every register reads 0.
  int          lat  [3] = '{31, 31, 8};
  bit          zr   [3] = '{1'b1, 1'b1, 1'b0};
  bit          byp  [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
  logic [31:0] m_mem [3][32];
  bit          m_ready [3] = '{1'b0, 1'b0, 1'b0};
  bit          armed   [3] = '{1'b0, 1'b0, 1'b0};
  int          m_cnt   [3] = '{0, 0, 0};

  task automatic model_edge(input int k, input logic rst, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd);
    if (rst) begin
      armed[k]   = 1'b1;
      m_ready[k] = 1'b0;
      m_cnt[k]   = 0;
    end else if (!m_ready[k]) begin
      m_cnt[k]++;
      if (m_cnt[k] == lat[k]) begin
        m_ready[k] = 1'b1;
        for (int i = 0; i < 32; i++) m_mem[k][i] = 32'h0;
      end
    end else if (we && !(zr[k] && wa == 5'd0)) begin
      m_mem[k][wa] = wd & mask[k];
    end
  endtask

  function automatic logic [31:0] model_read(input int k, input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (!m_ready[k]) return 32'h0;
    if (zr[k] && a == 5'd0) return 32'h0;
    if (byp[k] && we && a == wa) return wd & mask[k];
    return m_mem[k][a];
  endfunction

  always @(posedge clk) begin
    model_edge(0, rst_a, we_a, wa_a, wd_a);
    model_edge(1, rst_a, we_a, wa_a, wd_a);
    model_edge(2, rst_c, we_c, {2'b00, wa_c}, {16'h0, wd_c});
  end

  // Compare process: inputs only change just after posedge, so the
  // negedge sees settled combinational outputs.
  always @(negedge clk) begin
    if (armed[0]) begin
      check("a_ready", {31'h0, rdy_a}, {31'h0, m_ready[0]});
      check("a_rd1", rd1_a, model_read(0, ra1_a, we_a, wa_a, wd_a));
      check("a_rd2", rd2_a, model_read(0, ra2_a, we_a, wa_a, wd_a));
    end
    if (armed[1]) begin
      check("b_ready", {31'h0, rdy_b}, {31'h0, m_ready[1]});
      check("b_rd1", rd1_b, model_read(1, ra1_a, we_a, wa_a, wd_a));
      check("b_rd2", rd2_b, model_read(1, ra2_a, we_a, wa_a, wd_a));
    end
    if (armed[2]) begin
      check("c_ready", {31'h0, rdy_c}, {31'h0, m_ready[2]});
      check("c_rd1", {16'h0, rd1_c}, model_read(2, {2'b00, ra1_c}, we_c, {2'b00, wa_c}, {16'h0, wd_c}));
      check("c_rd2", {16'h0, rd2_c}, model_read(2, {2'b00, ra2_c}, we_c, {2'b00, wa_c}, {16'h0, wd_c}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int first_a, first_c;

  initial begin
    rst_a = 1'b1; we_a = 1'b0; ra1_a = '0; ra2_a = '0; wa_a = '0; wd_a = '0;
    rst_c = 1'b1; we_c = 1'b0; ra1_c = '0; ra2_c = '0; wa_c = '0; wd_c = '0;
    tick();
    tick();
    #1;
    check("reset_ready_a", {31'h0, rdy_a}, 32'h0);
    check("reset_rd1_a", rd1_a, 32'h0);
    check("reset_ready_c", {31'h0, rdy_c}, 32'h0);

    // Release reset with write requests pending that must be dropped.
    rst_a = 1'b0; rst_c = 1'b0;
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEAD_BEEF; ra1_a = 5'd5; ra2_a = 5'd7;
    we_c = 1'b1; wa_c = 3'd3; wd_c = 16'hBEEF; ra1_c = 3'd3; ra2_c = 3'd0;
    first_a = 0; first_c = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      #1;
      if (rdy_a && first_a == 0) first_a = i;
      if (rdy_c && first_c == 0) first_c = i;
      if (i == 5) we_c = 1'b0;
      if (i == 20) we_a = 1'b0;
    end
    check("clear_latency_a", first_a, 32'd31);
    check("clear_latency_c", first_c, 32'd8);
    check("clear_drop_reg5_a", rd1_a, 32'h0);
    check("clear_drop_reg3_c", {16'h0, rd1_c}, 32'h0);

    for (int i = 0; i < 32; i++) begin
      ra1_a = 5'(i); ra2_a = 5'(31 - i);
      #1;
      check("cleared_rd1_a", rd1_a, 32'h0);
      check("cleared_rd2_a", rd2_a, 32'h0);
      tick();
    end

    // Register 0 is hardwired to zero on a/b.
    we_a = 1'b1; wa_a = 5'd0; wd_a = 32'h1234_5678; ra1_a = 5'd0;
    #1;
    check("zero_reg_same_cycle", rd1_a, 32'h0);
    tick();
    we_a = 1'b0;
    #1;
    check("zero_reg_after", rd1_a, 32'h0);

    // Bypass: a forwards, b shows the old value until the edge.
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h1111_1111;
    tick();
    wd_a = 32'hA5A5_A5A5; ra1_a = 5'd7; ra2_a = 5'd7;
    #1;
    check("bypass_rd1_a", rd1_a, 32'hA5A5_A5A5);
    check("bypass_rd2_a", rd2_a, 32'hA5A5_A5A5);
    check("nobypass_rd1_b", rd1_b, 32'h1111_1111);
    check("nobypass_rd2_b", rd2_b, 32'h1111_1111);
    tick();
    we_a = 1'b0;
    #1;
    check("after_edge_rd1_b", rd1_b, 32'hA5A5_A5A5);
    check("after_edge_rd2_a", rd2_a, 32'hA5A5_A5A5);

    // Reset in READY, then again mid-clear at clear_ptr=10.
    we_a = 1'b1; wa_a = 5'd3; wd_a = 32'd9; ra1_a = 5'd3;
    tick();
    we_a = 1'b0;
    #1;
    check("reg3_written", rd1_a, 32'd9);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    #1;
    check("midclear_not_ready", {31'h0, rdy_a}, 32'h0);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    first_a = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      #1;
      if (rdy_a && first_a == 0) first_a = i;
    end
    check("restart_latency_a", first_a, 32'd31);
    check("reg3_cleared", rd1_a, 32'h0);

    // Small configuration: register 0 is ordinary storage, no aliasing.
    we_c = 1'b1; wa_c = 3'd0; wd_c = 16'hFFFF;
    tick();
    we_c = 1'b0; ra1_c = 3'd0;
    #1;
    check("c_reg0_ffff", {16'h0, rd1_c}, 32'h0000_FFFF);
    we_c = 1'b1; wa_c = 3'd7; wd_c = 16'h1234;
    tick();
    we_c = 1'b0; ra1_c = 3'd0; ra2_c = 3'd7;
    #1;
    check("c_reg0_no_alias", {16'h0, rd1_c}, 32'h0000_FFFF);
    check("c_reg7", {16'h0, rd2_c}, 32'h0000_1234);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor to the single-cycle CPU's 32x32 register file: generalised data width and depth, optional hardwired-zero register, optional write-to-read bypass.
- Adds a synchronous reset that clears every register through a sequential clear state machine, with a `ready` status output.
- Sits between decode and ALU in the single-cycle datapath and in the planned pipelined core, where bypass covers the write-back/decode overlap.
- Contents come from reset only; there is no file preload and no file dump.

Parameters:
- DATA_WIDTH, 32, bit width of each register and of all data ports.
- DEPTH, 32, number of registers; must be a power of two and at least 2.
- ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, when 1 a same-cycle write to the read address is forwarded to the read port.
- ADDR_WIDTH (localparam), clog2(DEPTH), width of every address port.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk; starts the clear sequence.
- read_register_1  input  ADDR_WIDTH  read port 1 address (rs).
- read_register_2  input  ADDR_WIDTH  read port 2 address (rt).
- write_register  input  ADDR_WIDTH  write address.
- write_data  input  DATA_WIDTH  data to write.
- sig_reg_write  input  1  write enable, sampled on rising edge of clk.
- read_data_1  output  DATA_WIDTH  combinational read data, port 1.
- read_data_2  output  DATA_WIDTH  combinational read data, port 2.
- ready  output  1  1 when the clear sequence is done and writes are accepted.

Behaviour:
- State machine has two states, CLEAR and READY. State and the clear pointer are the only registered control.
- Reset:
  - reset=1 at an edge puts the block in CLEAR, with clear_ptr = (ZERO_REG ? 1 : 0).
  - ready=0 from the edge where reset is sampled.
  - reset held high keeps the block in CLEAR with the pointer held at its start value.
  - reset asserted mid-clear restarts from the start value.
  - reset asserted in READY re-enters CLEAR.
- CLEAR state:
  - While reset=0, each edge writes 0 to registers[clear_ptr] and increments clear_ptr.
  - The edge that writes DEPTH-1 moves the block to READY. The pointer never wraps.
  - Latency from reset deassertion to ready=1 is DEPTH-1 cycles (ZERO_REG=1) or DEPTH cycles (ZERO_REG=0).
  - ready is registered and rises on the edge that writes register DEPTH-1.
  - sig_reg_write is ignored in CLEAR; the write is dropped, not queued.
- READY state:
  - At an edge with sig_reg_write=1, registers[write_register] <= write_data.
  - If ZERO_REG=1 and write_register=0, the write is discarded.
  - New data is visible on reads after the edge; with BYPASS=1 it is also visible in the same cycle (see below).
- Reads:
  - Purely combinational on the address, register contents, state and the write-port inputs.
  - While ready=0, both read_data outputs are forced to 0.
  - If ZERO_REG=1 and the address is 0, the output is 0 regardless of anything else.
- Bypass (BYPASS=1):
  - If ready=1, sig_reg_write=1, the address equals write_register, and the address is not the suppressed zero register, read_data = write_data.
  - Both ports bypass independently; both may bypass in the same cycle.
- BYPASS=0: a read of the register being written returns the old value until the edge.
- Storage is uninitialised before the first reset. Nothing is guaranteed until ready=1 has been seen once.
- There are no X-propagation guarantees on address inputs with X.

Test Plan:
- Clear sequence (DEPTH=32, ZERO_REG=1): reset=1 for 2 cycles, then 0 → ready=0 for exactly 31 edges after deassertion, ready=1 after the 31st; every read of 0..31 returns 0.
- Writes ignored during clear: sig_reg_write=1, write_register=5, write_data=32'hDEADBEEF issued during CLEAR → after ready=1, reading register 5 returns 0.
- Zero-register protection: in READY, write 32'h12345678 to register 0 → read_data_1 at address 0 returns 0, both in the write cycle and afterwards.
- Same-cycle bypass:
  - Setup: BYPASS=1, write 32'hA5A5A5A5 to register 7 while read_register_1=7 and read_register_2=7.
  - Required: both outputs show A5A5A5A5 in that cycle.
  - Same stimulus with BYPASS=0: both outputs show the previous value that cycle and A5A5A5A5 after the edge.
- Reset mid-clear:
  - Setup: assert reset for 1 cycle when clear_ptr=10.
  - Required: the sequence restarts; ready rises 31 edges after deassertion.
  - Required: a register written before that reset (e.g. register 3 = 9) reads 0 afterwards.
- Parameter sweep (DATA_WIDTH=16, DEPTH=8, ZERO_REG=0):
  - Clear takes 8 cycles.
  - Write 16'hFFFF to register 0 → reads 16'hFFFF.
  - Write to register 7 → no wrap or aliasing into register 0.
